// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM states, requester
// indices and the fixed select encoding of the 4:1 mux.
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] A = 2'd0;
  localparam logic [1:0] B = 2'd1;
  localparam logic [1:0] C = 2'd2;
  localparam logic [1:0] D = 2'd3;

  localparam logic [1:0] SEL_A = 2'b01;
  localparam logic [1:0] SEL_B = 2'b00;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  // The mux select does not follow requester index order.
  function automatic logic [1:0] sel_of(input logic [1:0] idx);
    logic [1:0] s;
    case (idx)
      A:       s = SEL_A;
      B:       s = SEL_B;
      C:       s = SEL_C;
      default: s = SEL_D;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mux4.sv
// The shared 4:1 select mux: output is the input whose number equals i_sel.
module mux4 #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_in0,
  input  logic [W-1:0] i_in1,
  input  logic [W-1:0] i_in2,
  input  logic [W-1:0] i_in3,
  input  logic [1:0]   i_sel,
  output logic [W-1:0] o_out
);

  always_comb begin
    o_out = i_in0;
    case (i_sel)
      2'b00:   o_out = i_in0;
      2'b01:   o_out = i_in1;
      2'b10:   o_out = i_in2;
      default: o_out = i_in3;
    endcase
  end

endmodule

// File: rtl/mux_arb_rr_pick4.sv
// Combinational round-robin pick: first requesting index at or after i_ptr,
// wrapping 3 -> 0.
module rr_pick4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_pick,
  output logic [1:0] o_idx,
  output logic       o_any
);

  logic [1:0] w_cand;

  always_comb begin
    o_pick = 4'b0000;
    o_idx  = 2'd0;
    o_any  = 1'b0;
    w_cand = i_ptr;
    for (int k = 0; k < 4; k++) begin
      w_cand = i_ptr + 2'(k);
      if (!o_any && i_req[w_cand]) begin
        o_any          = 1'b1;
        o_idx          = w_cand;
        o_pick[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with bounded
// bursts of HOLD_MAX beats and a valid/ready output toward one consumer.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W        = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  input  logic [W-1:0] data_c,
  input  logic [W-1:0] data_d,
  input  logic         out_ready,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic [3:0]   ack,
  output state_t       dbg_state
);

  // Handshake: a beat transfers in any cycle with out_valid && out_ready;
  // out_valid never depends on out_ready, and ack pulses for exactly that cycle.

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  logic [3:0]   w_pick;
  logic [1:0]   w_idx;
  logic         w_any;
  logic [W-1:0] w_mux_out;
  logic         w_valid;
  logic         w_xfer;
  logic         w_last;

  rr_pick4 u_pick (
    .i_req  (req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  mux4 #(.W(W)) u_mux (
    .i_in0 (data_b),
    .i_in1 (data_a),
    .i_in2 (data_c),
    .i_in3 (data_d),
    .i_sel (r_sel),
    .o_out (w_mux_out)
  );

  assign w_valid   = (r_state == GRANT) && req[r_owner];
  assign w_xfer    = w_valid && out_ready;
  assign w_last    = (r_cnt == 4'(HOLD_MAX - 1));
  assign out_valid = w_valid;
  assign out_data  = w_valid ? w_mux_out : '0;
  assign ack       = w_xfer ? r_gnt : 4'b0000;
  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign dbg_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_pick;
          w_sel_nxt   = sel_of(w_idx);
          w_owner_nxt = w_idx;
          w_cnt_nxt   = 4'd0;
        end
      end
      GRANT: begin
        if (w_xfer) w_cnt_nxt = r_cnt + 4'd1;
        // Owner withdrew, or its last allowed beat just went out.
        if (!req[r_owner] || (w_xfer && w_last)) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = 4'b0000;
          w_ptr_nxt   = r_owner + 2'd1;
          w_cnt_nxt   = 4'd0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'b00;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
